grain128a_ctrl: RTL and testbench

Sequencer that sits between a host and the `grain128a` core. It accepts a parallel 128-bit key and 96-bit IV and drives the core's bit-serial load sequence: INIT, then key and IV serially. It then packs the core's serial keystream into WORD_W-bit words behind a valid/ready handshake. When the consumer stalls, the block stalls the core by gating the core's clock enable, so no keystream bit is ever lost.

---
 rtl/grain128a_ctrl_if.sv | 21 ++
 rtl/grain128a_ctrl.sv | 143 ++++++++++++++
 tb/tb_grain128a_ctrl.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grain128a_ctrl_if.sv
// Keystream word handshake between grain128a_ctrl and its consumer.
// master: WORD_O/WORD_VALID_O out, WORD_READY_I in; slave is the mirror.
interface grain128a_ctrl_if #(
  parameter int WORD_W = 32
) ();
  logic [WORD_W-1:0] WORD_O;
  logic              WORD_VALID_O;
  logic              WORD_READY_I;

  modport master (
    output WORD_O,
    output WORD_VALID_O,
    input  WORD_READY_I
  );

  modport slave (
    input  WORD_O,
    input  WORD_VALID_O,
    output WORD_READY_I
  );
endinterface

// File: rtl/grain128a_ctrl.sv
// Grain-128a sequencer: serial key/IV load, keystream word packing.
// Ports: host START/KEY/IV/STOP/READY, core G_*, word handshake in wif.
module grain128a_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic          CLK_I,
  input  logic          RESETN_I,
  input  logic          CLKEN_I,
  input  logic          START_I,
  input  logic [127:0]  KEY_I,
  input  logic [95:0]   IV_I,
  input  logic          STOP_I,
  output logic          READY_O,
  output logic          G_CLKEN_O,
  output logic          G_INIT_O,
  output logic          G_KEY_O,
  output logic          G_IV_O,
  input  logic          G_KS_I,
  input  logic          G_KSVALID_I,
  grain128a_ctrl_if.master wif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_KEYIV,
    S_KEY,
    S_STREAM
  } state_e;

  localparam logic [6:0] BCNT_LAST = 7'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [127:0]      key_q, key_d;
  logic [95:0]       iv_q, iv_d;
  logic [WORD_W-1:0] ws_q, ws_d;
  logic [6:0]        bcnt_q, bcnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wvalid_q, wvalid_d;
  logic              stall;
  logic              tick;

  // Stalling gates the core too, so no keystream bit is dropped.
  assign stall     = wvalid_q & ~wif.WORD_READY_I;
  assign tick      = CLKEN_I & ~stall;
  assign G_CLKEN_O = tick;

  assign READY_O  = (state_q == S_IDLE);
  assign G_INIT_O = (state_q == S_INIT);
  assign G_KEY_O  = ((state_q == S_KEYIV) || (state_q == S_KEY))
                    & key_q[127];
  assign G_IV_O   = (state_q == S_KEYIV) & iv_q[95];

  assign wif.WORD_O       = word_q;
  assign wif.WORD_VALID_O = wvalid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    iv_d     = iv_q;
    ws_d     = ws_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    wvalid_d = wvalid_q;
    if (wvalid_q && wif.WORD_READY_I) begin
      wvalid_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (START_I) begin
          key_d   = KEY_I;
          iv_d    = IV_I;
          cnt_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        state_d = S_KEYIV;
      end
      S_KEYIV: begin
        key_d = {key_q[126:0], 1'b0};
        iv_d  = {iv_q[94:0], 1'b0};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd95) begin
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        key_d = {key_q[126:0], 1'b0};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (STOP_I) begin
          state_d  = S_IDLE;
          ws_d     = '0;
          bcnt_d   = '0;
          wvalid_d = 1'b0;
        end else if (G_KSVALID_I) begin
          ws_d = WORD_W'({ws_q, G_KS_I});
          if (bcnt_q == BCNT_LAST) begin
            // Completing word replaces one consumed this cycle.
            word_d   = ws_d;
            wvalid_d = 1'b1;
            bcnt_d   = '0;
          end else begin
            bcnt_d = bcnt_q + 7'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RESETN_I) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      ws_q     <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
    end else if (tick) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      ws_q     <= ws_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
    end
  end

endmodule

// File: tb/tb_grain128a_ctrl.sv
// Bench for grain128a_ctrl: random core stand-in and bit-queue model.
// Checks load order, word packing, stall, stop, reset and ignored start.
module tb_grain128a_ctrl;

  localparam int W = 32;

  logic         CLK_I = 1'b0;
  logic         RESETN_I;
  logic         CLKEN_I;
  logic         START_I;
  logic [127:0] KEY_I;
  logic [95:0]  IV_I;
  logic         STOP_I;
  logic         READY_O;
  logic         G_CLKEN_O;
  logic         G_INIT_O;
  logic         G_KEY_O;
  logic         G_IV_O;
  logic         ks_q;
  logic         ksv_q;
  logic         rdy;

  grain128a_ctrl_if #(.WORD_W(W)) wif ();

  assign wif.WORD_READY_I = rdy;

  grain128a_ctrl #(.WORD_W(W)) dut (
    .CLK_I       (CLK_I),
    .RESETN_I    (RESETN_I),
    .CLKEN_I     (CLKEN_I),
    .START_I     (START_I),
    .KEY_I       (KEY_I),
    .IV_I        (IV_I),
    .STOP_I      (STOP_I),
    .READY_O     (READY_O),
    .G_CLKEN_O   (G_CLKEN_O),
    .G_INIT_O    (G_INIT_O),
    .G_KEY_O     (G_KEY_O),
    .G_IV_O      (G_IV_O),
    .G_KS_I      (ks_q),
    .G_KSVALID_I (ksv_q),
    .wif         (wif)
  );

  always #5 CLK_I = ~CLK_I;

  int tests = 0;
  int fails = 0;

  // Core stand-in state: 0 idle, 1 loading, 2 streaming.
  int           mphase;
  int           ld;
  int           warm;
  int           init_cnt;
  int           viol;
  logic [127:0] key_rx;
  logic [95:0]  iv_rx;
  bit           bits[$];
  logic [W-1:0] got[$];
  bit           hold = 1'b0;

  initial begin
    ks_q  = 1'b0;
    ksv_q = 1'b0;
    forever begin
      @(posedge CLK_I);
      if (!RESETN_I) begin
        mphase = 0;
        ks_q  <= 1'b0;
        ksv_q <= 1'b0;
      end else begin
        if (CLKEN_I && wif.WORD_VALID_O && rdy)
          got.push_back(wif.WORD_O);
        if (G_CLKEN_O) begin
          if (G_INIT_O) begin
            mphase = 1;
            ld = 0;
            init_cnt++;
            ksv_q <= 1'b0;
          end else if (mphase == 1) begin
            key_rx = {key_rx[126:0], G_KEY_O};
            if (ld < 96) iv_rx = {iv_rx[94:0], G_IV_O};
            else if (G_IV_O) viol++;
            ld++;
            if (ld == 128) begin
              mphase = 2;
              warm = $urandom_range(3, 20);
            end
          end else begin
            if (G_KEY_O || G_IV_O) viol++;
            if (mphase == 2) begin
              if (ksv_q) bits.push_back(ks_q);
              if (warm > 0) begin
                warm--;
                ksv_q <= 1'b0;
              end else begin
                ksv_q <= ($urandom_range(0, 4) != 0);
                ks_q  <= 1'($urandom & 1);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    CLKEN_I = 1'b0;
    rdy = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (hold) begin
        CLKEN_I = 1'b1;
        rdy = 1'b0;
      end else begin
        CLKEN_I = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 9) < 7);
      end
    end
  end

  // Word i as the first-received-is-MSB packing of the bit queue.
  function automatic logic [W-1:0] exp_word(int i);
    logic [W-1:0] w;
    if (bits.size() < (i + 1) * W) return 'x;
    w = '0;
    for (int j = 0; j < W; j++) w = (w << 1) | W'(bits[i*W+j]);
    return w;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_model();
    mphase = 0;
    ld = 0;
    init_cnt = 0;
    viol = 0;
    key_rx = '0;
    iv_rx = '0;
    bits.delete();
    got.delete();
  endtask

  task automatic start_load(input logic [127:0] k, input logic [95:0] v);
    int n;
    @(negedge CLK_I);
    clear_model();
    KEY_I = k;
    IV_I = v;
    START_I = 1'b1;
    n = 0;
    while (init_cnt == 0 && n < 500) begin
      @(negedge CLK_I);
      n++;
    end
    START_I = 1'b0;
    KEY_I = rnd128();
    IV_I = 96'(rnd128());
    tests++;
    if (init_cnt == 0) begin
      fails++;
      $display("FAIL start_timeout: init_cnt=%0d need 1", init_cnt);
    end
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 6000) begin
      @(negedge CLK_I);
      c++;
    end
    tests++;
    if (got.size() < n) begin
      fails++;
      $display("FAIL word_timeout: got %0d words need %0d", got.size(), n);
    end
  endtask

  task automatic stop_stream();
    int c;
    @(negedge CLK_I);
    STOP_I = 1'b1;
    c = 0;
    @(negedge CLK_I);
    while (READY_O !== 1'b1 && c < 200) begin
      @(negedge CLK_I);
      c++;
    end
    STOP_I = 1'b0;
  endtask

  task automatic test_reset();
    RESETN_I = 1'b0;
    START_I = 1'b0;
    STOP_I = 1'b0;
    KEY_I = '0;
    IV_I = '0;
    repeat (2) @(posedge CLK_I);
    #1;
    tests += 6;
    if (READY_O !== 1'b1) begin
      fails++; $display("FAIL rst_ready: got %b need 1", READY_O);
    end
    if (wif.WORD_VALID_O !== 1'b0) begin
      fails++; $display("FAIL rst_wvalid: got %b need 0", wif.WORD_VALID_O);
    end
    if (wif.WORD_O !== '0) begin
      fails++; $display("FAIL rst_word: got %h need 0", wif.WORD_O);
    end
    if ({G_INIT_O, G_KEY_O, G_IV_O} !== 3'b000) begin
      fails++;
      $display("FAIL rst_gout: got %b need 000", {G_INIT_O, G_KEY_O, G_IV_O});
    end
    if (G_CLKEN_O !== CLKEN_I) begin
      fails++; $display("FAIL rst_gclken: got %b need %b", G_CLKEN_O, CLKEN_I);
    end
    @(negedge CLK_I);
    RESETN_I = 1'b1;
    @(posedge CLK_I);
    #1;
    if (READY_O !== 1'b1) begin
      fails++; $display("FAIL idle_ready: got %b need 1", READY_O);
    end
  endtask

  task automatic test_stream(input string tag, input logic [127:0] k,
                             input logic [95:0] v);
    start_load(k, v);
    wait_words(8);
    tests += 4;
    if (key_rx !== k) begin
      fails++; $display("FAIL %s_key: got %h need %h", tag, key_rx, k);
    end
    if (iv_rx !== v) begin
      fails++; $display("FAIL %s_iv: got %h need %h", tag, iv_rx, v);
    end
    if (init_cnt !== 1) begin
      fails++; $display("FAIL %s_init: got %0d need 1", tag, init_cnt);
    end
    if (viol !== 0) begin
      fails++; $display("FAIL %s_idle_bits: got %0d need 0", tag, viol);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL %s_word%0d: got %h need %h", tag, i, got[i], exp_word(i));
      end
    end
    stop_stream();
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    int c;
    start_load('0, 96'h800000000000000000000000);
    wait_words(2);
    hold = 1'b1;
    c = 0;
    @(posedge CLK_I);
    #1;
    while (wif.WORD_VALID_O !== 1'b1 && c < 3000) begin
      @(posedge CLK_I);
      #1;
      c++;
    end
    w = wif.WORD_O;
    repeat (20) begin
      @(posedge CLK_I);
      #1;
      tests += 3;
      if (G_CLKEN_O !== 1'b0) begin
        fails++; $display("FAIL stall_gclken: got %b need 0", G_CLKEN_O);
      end
      if (wif.WORD_O !== w) begin
        fails++; $display("FAIL stall_word: got %h need %h", wif.WORD_O, w);
      end
      if (wif.WORD_VALID_O !== 1'b1) begin
        fails++; $display("FAIL stall_valid: got %b need 1", wif.WORD_VALID_O);
      end
    end
    hold = 1'b0;
    wait_words(8);
    tests++;
    if (iv_rx !== 96'h800000000000000000000000) begin
      fails++; $display("FAIL stall_iv: got %h", iv_rx);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL stall_word%0d: got %h need %h", i, got[i], exp_word(i));
      end
    end
    stop_stream();
  endtask

  task automatic test_stop();
    int c;
    logic [127:0] k;
    logic [95:0] v;
    start_load(rnd128(), 96'(rnd128()));
    wait_words(2);
    @(negedge CLK_I);
    STOP_I = 1'b1;
    c = 0;
    @(negedge CLK_I);
    while (READY_O !== 1'b1 && c < 200) begin
      @(negedge CLK_I);
      c++;
    end
    STOP_I = 1'b0;
    tests += 2;
    if (READY_O !== 1'b1) begin
      fails++; $display("FAIL stop_ready: got %b need 1", READY_O);
    end
    if (wif.WORD_VALID_O !== 1'b0) begin
      fails++; $display("FAIL stop_valid: got %b need 0", wif.WORD_VALID_O);
    end
    for (int i = 0; i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL stop_word%0d: got %h need %h", i, got[i], exp_word(i));
      end
    end
    k = 128'h0123456789abcdef123456789abcdef0;
    v = 96'h8123456789abcdef12345678;
    start_load(k, v);
    wait_words(8);
    tests += 2;
    if (key_rx !== k || iv_rx !== v) begin
      fails++; $display("FAIL restart_load: got %h %h", key_rx, iv_rx);
    end
    if (init_cnt !== 1) begin
      fails++; $display("FAIL restart_init: got %0d need 1", init_cnt);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL restart_word%0d: got %h need %h", i, got[i], exp_word(i));
      end
    end
    stop_stream();
  endtask

  task automatic test_reset_midload();
    int c;
    start_load(rnd128(), 96'(rnd128()));
    c = 0;
    while (!(mphase == 1 && ld >= 50) && c < 1000) begin
      @(negedge CLK_I);
      c++;
    end
    RESETN_I = 1'b0;
    @(posedge CLK_I);
    #1;
    tests += 5;
    if (READY_O !== 1'b1) begin
      fails++; $display("FAIL mrst_ready: got %b need 1", READY_O);
    end
    if (wif.WORD_VALID_O !== 1'b0) begin
      fails++; $display("FAIL mrst_wvalid: got %b need 0", wif.WORD_VALID_O);
    end
    if (wif.WORD_O !== '0) begin
      fails++; $display("FAIL mrst_word: got %h need 0", wif.WORD_O);
    end
    if ({G_INIT_O, G_KEY_O, G_IV_O} !== 3'b000) begin
      fails++;
      $display("FAIL mrst_gout: got %b need 000", {G_INIT_O, G_KEY_O, G_IV_O});
    end
    if (G_CLKEN_O !== CLKEN_I) begin
      fails++; $display("FAIL mrst_gclken: got %b need %b", G_CLKEN_O, CLKEN_I);
    end
    @(negedge CLK_I);
    RESETN_I = 1'b1;
    start_load('0, '0);
    wait_words(5);
    tests++;
    if (key_rx !== '0 || iv_rx !== '0 || init_cnt !== 1) begin
      fails++; $display("FAIL mrst_load: got %h %h %0d", key_rx, iv_rx, init_cnt);
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL mrst_word%0d: got %h need %h", i, got[i], exp_word(i));
      end
    end
    stop_stream();
  endtask

  task automatic test_ignored_start();
    int c;
    logic [127:0] k;
    logic [95:0] v;
    k = rnd128();
    v = 96'(rnd128());
    start_load(k, v);
    c = 0;
    while (!(mphase == 1 && ld >= 30) && c < 1000) begin
      @(negedge CLK_I);
      c++;
    end
    START_I = 1'b1;
    KEY_I = rnd128();
    repeat (10) @(negedge CLK_I);
    START_I = 1'b0;
    wait_words(2);
    @(negedge CLK_I);
    START_I = 1'b1;
    IV_I = 96'(rnd128());
    repeat (10) @(negedge CLK_I);
    START_I = 1'b0;
    wait_words(6);
    tests += 3;
    if (key_rx !== k) begin
      fails++; $display("FAIL ign_key: got %h need %h", key_rx, k);
    end
    if (iv_rx !== v) begin
      fails++; $display("FAIL ign_iv: got %h need %h", iv_rx, v);
    end
    if (init_cnt !== 1) begin
      fails++; $display("FAIL ign_init: got %0d need 1", init_cnt);
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp_word(i)) begin
        fails++;
        $display("FAIL ign_word%0d: got %h need %h", i, got[i], exp_word(i));
      end
    end
    stop_stream();
  endtask

  initial begin
    test_reset();
    test_stream("zero", '0, '0);
    test_stream("vec", 128'h0123456789abcdef123456789abcdef0,
                96'h0123456789abcdef12345678);
    test_stream("rand", rnd128(), 96'(rnd128()));
    test_stall();
    test_stop();
    test_reset_midload();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
